network_acc_requant: RTL and testbench

Downstream stage of the 16s×12s→28-bit product multiplier in the convolution datapath. Consumes a stream of signed 28-bit products and accumulates one output pixel's kernel window onto a per-window bias. On the window's last product it rounds, shifts and saturates the sum back to a 16-bit activation. It then presents the activation on a valid/ready handshake to the next layer buffer.

---
 rtl/network_acc_requant.sv | 130 +++++++++++++
 tb/tb_network_acc_requant.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/network_acc_requant.sv
// Windowed accumulate-and-requantize stage: sums signed products onto a shifted bias,
// then rounds, shifts and saturates to an activation. Optional ReLU via NETWORK_ACC_RELU_EN.
module network_acc_requant #(
    parameter int unsigned PROD_W = 28,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned SHIFT  = 10
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] in_data,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [OUT_W-1:0]  bias,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     acc_ovf
);

    localparam int unsigned RW = ACC_W + 1;
    localparam logic [RW-1:0]        HALF    = RW'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     first_q, first_d;
    logic                     ovf_q, ovf_d;
    logic                     rdy_q, rdy_d;
    logic                     vld_q, vld_d;
    logic signed [OUT_W-1:0]  dout_q, dout_d;

    logic signed [ACC_W-1:0]  bias_ext, prod_ext, add_a, sum;
    logic                     add_ovf;
    logic signed [RW-1:0]     rnd, shifted;
    logic signed [OUT_W-1:0]  quant;

    // Adder operands: the first beat of a window starts from the scaled bias.
    always_comb begin
        bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
        prod_ext = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
        add_a    = first_q ? (bias_ext <<< SHIFT) : acc_q;
        sum      = add_a + prod_ext;
        add_ovf  = (add_a[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != add_a[ACC_W-1]);
    end

    // Round half up in one extra bit so the rounding add itself cannot wrap.
    always_comb begin
        rnd     = {sum[ACC_W-1], sum} + HALF;
        shifted = rnd >>> SHIFT;
        if (shifted > SAT_MAX) begin
            quant = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            quant = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            quant = shifted[OUT_W-1:0];
        end
`ifdef NETWORK_ACC_RELU_EN
        if (quant[OUT_W-1]) begin
            quant = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        first_d = first_q;
        ovf_d   = ovf_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        dout_d  = dout_q;
        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    acc_d   = sum;
                    first_d = 1'b0;
                    if (add_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_OUT;
                        rdy_d   = 1'b0;
                        vld_d   = 1'b1;
                        dout_d  = quant;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                    rdy_d   = 1'b1;
                    vld_d   = 1'b0;
                    first_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
        end
    end

    // Ready is held low for the whole reset pulse, high as soon as it releases.
    assign in_ready  = rdy_q & ~ap_rst;
    assign out_valid = vld_q;
    assign out_data  = dout_q;
    assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_network_acc_requant.sv
// Directed scoreboard bench for network_acc_requant (default parameters).
module tb_network_acc_requant;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic signed [27:0] in_data = '0;
    logic               in_last = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] bias = '0;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               acc_ovf;

    int     tests = 0;
    int     fails = 0;
    longint sb[$];

    localparam logic signed [27:0] PMAX = 28'sh7FFFFFF;

    network_acc_requant dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bias     (bias),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc_ovf  (acc_ovf)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic longint relu(input longint x);
`ifdef NETWORK_ACC_RELU_EN
        return (x < 0) ? 64'sd0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] b, input logic signed [27:0] d, input bit last);
        @(negedge ap_clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        bias     = b;
    endtask

    // Wait for a result, compare against the scoreboard head, then complete the handshake.
    task automatic collect(input string tag);
        int     n;
        longint exp;
        n = 0;
        @(negedge ap_clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (!out_valid && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        chk({tag, "_latency"}, n, 0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
            exp = 0;
        end else begin
            exp = sb.pop_front();
        end
        chk(tag, out_data, exp);
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, out_valid, 0);
        chk({tag, "_rdy_back"}, in_ready, 1);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_acc_ovf", acc_ovf, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Three-beat accumulate
        send(0, 1024, 0);
        send(0, 2048, 0);
        sb.push_back(6);
        send(0, 3072, 1);
        collect("accum3");

        // Rounding, single-beat windows
        sb.push_back(2);
        send(0, 1536, 1);
        collect("rnd_1536");
        sb.push_back(relu(-1));
        send(0, -1536, 1);
        collect("rnd_m1536");
        sb.push_back(0);
        send(0, 511, 1);
        collect("rnd_511");
        sb.push_back(1);
        send(0, 512, 1);
        collect("rnd_512");

        // Saturation with extreme bias
        sb.push_back(32767);
        send(16'sd32767, 4096, 1);
        collect("sat_pos");
        sb.push_back(relu(-32768));
        send(-16'sd32768, -4096, 1);
        collect("sat_neg");

        // Backpressure: (3<<10)+2000-100 = 4972 -> 5
        send(3, 2000, 0);
        send(3, -100, 1);
        @(negedge ap_clk);
        in_valid = 1'b1;
        in_data  = 28'sd9999;
        in_last  = 1'b1;
        bias     = 16'sd7;
        chk("bp_vld", out_valid, 1);
        chk("bp_data0", out_data, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk("bp_hold_vld", out_valid, 1);
            chk("bp_hold_data", out_data, 5);
            chk("bp_hold_rdy", in_ready, 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk("bp_vld_drop", out_valid, 0);
        chk("bp_rdy_back", in_ready, 1);
        // Fresh window: (-2<<10)+700 = -1348 -> -1
        sb.push_back(relu(-1));
        send(-2, 700, 1);
        collect("bp_fresh");

        // Overflow: 4096 max products fit, the 4097th wraps; total wraps to -8192 -> -8
        for (int i = 0; i < 4096; i++) send(0, PMAX, 0);
        @(negedge ap_clk);
        in_valid = 1'b0;
        chk("ovf_before_wrap", acc_ovf, 0);
        send(0, PMAX, 0);
        @(negedge ap_clk);
        in_valid = 1'b0;
        chk("ovf_on_wrap", acc_ovf, 1);
        for (int i = 0; i < 4094; i++) send(0, PMAX, 0);
        sb.push_back(relu(-8));
        send(0, PMAX, 1);
        collect("ovf_result");
        sb.push_back(1);
        send(0, 1024, 1);
        collect("post_ovf_clean");
        chk("ovf_sticky", acc_ovf, 1);

        // Reset mid-window discards the partial sum
        send(0, 1024, 0);
        send(0, 1024, 0);
        send(0, 1024, 0);
        @(negedge ap_clk);
        in_valid = 1'b0;
        ap_rst   = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_vld", out_valid, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("mid_rst_ovf_clr", acc_ovf, 0);
        chk("mid_rst_rdy", in_ready, 1);
        sb.push_back(2);
        send(0, 1024, 0);
        send(0, 1024, 1);
        collect("after_rst");
        repeat (3) @(negedge ap_clk);
        chk("no_stray_out", out_valid, 0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
